sw_key_mmio_port: RTL

- Memory-mapped input peripheral that answers CPU data-memory reads of the board switches and push-buttons.
- Synchronises and debounces SW[9:0] and KEY[3:1], then presents state plus sticky change/press flags in a 4-word register window.
- Sits on the CPU data bus beside the LED output register, on the read side of the same I/O map.
- Provides the `irq` summary for polled or interrupt-driven firmware.

---
 rtl/io_map_pkg.sv | 22 ++
 rtl/input_debouncer.sv | 58 +++++
 rtl/sw_key_mmio_port.sv | 137 +++++++++++++
 3 files changed

// File: rtl/io_map_pkg.sv
// Shared I/O map for the CPU data bus: switch/key window and LED register.
// Offsets are word offsets inside the 4-word switch/key window.
package io_map_pkg;

    localparam logic [15:0] SW_KEY_BASE   = 16'hC000;
    localparam logic [15:0] LED_ADDR      = 16'hC010;

    localparam logic [1:0]  OFF_SW_STATE  = 2'd0;
    localparam logic [1:0]  OFF_SW_CHG    = 2'd1;
    localparam logic [1:0]  OFF_KEY_STATE = 2'd2;
    localparam logic [1:0]  OFF_KEY_PRS   = 2'd3;

    localparam logic [15:0] WINDOW_WORDS  = 16'd4;

    // True when addr falls inside base..base+3; the unsigned subtraction also rejects addresses below base.
    function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base);
        logic [15:0] off;
        off = addr - base;
        return (off < WINDOW_WORDS);
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Per-bit sample-history debouncer; a new level commits only after DB_SAMPLES
// equal samples taken on the shared tick.
module input_debouncer #(
    parameter int WIDTH      = 10,
    parameter int DB_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0][DB_SAMPLES-1:0] hist_r;
    logic [WIDTH-1:0]                 db_r;
    logic [WIDTH-1:0]                 rise_s;
    logic [WIDTH-1:0]                 fall_s;

    // Sample history: shift in the synchronised level on every tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_r <= '0;
        end else if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                hist_r[i] <= {hist_r[i][DB_SAMPLES-2:0], in_sync[i]};
            end
        end else begin
            hist_r <= hist_r;
        end
    end

    // Commit detection: a full history of the opposite level flips the bit.
    always_comb begin
        rise_s = '0;
        fall_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rise_s[i] = (&hist_r[i]) & ~db_r[i];
            fall_s[i] = ~(|hist_r[i]) & db_r[i];
        end
    end

    // Debounced level register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_r <= '0;
        end else begin
            db_r <= (db_r | rise_s) & ~fall_s;
        end
    end

    // rise/fall are decoded from registered state and are valid in the cycle before db flips.
    assign db   = db_r;
    assign rise = rise_s;
    assign fall = fall_s;

endmodule

// File: rtl/sw_key_mmio_port.sv
// Read-side MMIO peripheral for board switches and push-buttons: synchronise,
// debounce, and expose state plus sticky W1C change/press flags with an irq summary.
module sw_key_mmio_port
    import io_map_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = SW_KEY_BASE,
    parameter int          NUM_SW     = 10,
    parameter int          NUM_KEY    = 3,
    parameter int          DB_TICK    = 50000,
    parameter int          DB_SAMPLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SW-1:0]  SW,
    input  logic [NUM_KEY-1:0] KEY,
    input  logic [15:0]        addr,
    input  logic               re,
    input  logic               we,
    input  logic [15:0]        wdata,
    output logic [15:0]        rdata,
    output logic               irq
);

    localparam int PW = (DB_TICK > 1) ? $clog2(DB_TICK) : 1;

    logic [PW-1:0]      pre_cnt_r;
    logic               tick_s;
    logic [NUM_SW-1:0]  sw_meta_r,  sw_sync_r;
    logic [NUM_KEY-1:0] key_meta_r, key_sync_r;
    logic [NUM_SW-1:0]  sw_db_s,  sw_rise_s,  sw_fall_s;
    logic [NUM_KEY-1:0] key_db_s, key_rise_s, key_fall_s;
    logic [NUM_SW-1:0]  sw_chg_r,  sw_chg_nxt_s,  sw_clr_s;
    logic [NUM_KEY-1:0] key_prs_r, key_prs_nxt_s, key_clr_s;
    logic [15:0]        off_s;
    logic               in_win_s;
    logic [15:0]        rd_val_s;
    logic [15:0]        rdata_r;
    logic               irq_r;

    assign tick_s = (pre_cnt_r == PW'(DB_TICK - 1));

    // Free-running prescaler shared by both debouncer instances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt_r <= '0;
        end else if (tick_s) begin
            pre_cnt_r <= '0;
        end else begin
            pre_cnt_r <= pre_cnt_r + PW'(1);
        end
    end

    // Two-flop synchronisers; KEY flops rest at 1 because the buttons are active-low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_meta_r  <= '0;
            sw_sync_r  <= '0;
            key_meta_r <= '1;
            key_sync_r <= '1;
        end else begin
            sw_meta_r  <= SW;
            sw_sync_r  <= sw_meta_r;
            key_meta_r <= KEY;
            key_sync_r <= key_meta_r;
        end
    end

    input_debouncer #(.WIDTH(NUM_SW), .DB_SAMPLES(DB_SAMPLES)) u_sw_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick_s),
        .in_sync (sw_sync_r),
        .db      (sw_db_s),
        .rise    (sw_rise_s),
        .fall    (sw_fall_s)
    );

    input_debouncer #(.WIDTH(NUM_KEY), .DB_SAMPLES(DB_SAMPLES)) u_key_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick_s),
        .in_sync (~key_sync_r),
        .db      (key_db_s),
        .rise    (key_rise_s),
        .fall    (key_fall_s)
    );

    assign off_s    = addr - BASE_ADDR;
    assign in_win_s = in_window(addr, BASE_ADDR);

    // W1C decode and next flag values; a set event in the same cycle overrides the clear.
    always_comb begin
        sw_clr_s  = '0;
        key_clr_s = '0;
        if (we && in_win_s && (off_s[1:0] == OFF_SW_CHG)) begin
            sw_clr_s = wdata[NUM_SW-1:0];
        end else if (we && in_win_s && (off_s[1:0] == OFF_KEY_PRS)) begin
            key_clr_s = wdata[NUM_KEY-1:0];
        end else begin
            sw_clr_s  = '0;
            key_clr_s = '0;
        end
        sw_chg_nxt_s  = (sw_chg_r & ~sw_clr_s) | sw_rise_s | sw_fall_s;
        key_prs_nxt_s = (key_prs_r & ~key_clr_s) | (key_rise_s & ~key_fall_s);
    end

    // Register read mux; the values are pre-write so a simultaneous write is not visible.
    always_comb begin
        rd_val_s = 16'h0000;
        case (off_s[1:0])
            OFF_SW_STATE:  rd_val_s = 16'(sw_db_s);
            OFF_SW_CHG:    rd_val_s = 16'(sw_chg_r);
            OFF_KEY_STATE: rd_val_s = 16'(key_db_s);
            OFF_KEY_PRS:   rd_val_s = 16'(key_prs_r);
            default:       rd_val_s = 16'h0000;
        endcase
    end

    // Sticky flags, irq summary and read data; rdata idles at zero for bus OR-ing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_chg_r  <= '0;
            key_prs_r <= '0;
            irq_r     <= 1'b0;
            rdata_r   <= 16'h0000;
        end else begin
            sw_chg_r  <= sw_chg_nxt_s;
            key_prs_r <= key_prs_nxt_s;
            irq_r     <= (|sw_chg_nxt_s) | (|key_prs_nxt_s);
            rdata_r   <= (re && in_win_s) ? rd_val_s : 16'h0000;
        end
    end

    assign rdata = rdata_r;
    assign irq   = irq_r;

endmodule
